// File: rtl/maze_pkg.sv
// Shared maze definitions: direction codes, player FSM encoding and grid limits.
// Used by the solver controller and the path player.
package maze_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_UP    = 2'b11
    } dir_t;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EMIT  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_STEP  = 3'd4;
    localparam logic [2:0] S_FIN   = 3'd5;

    localparam logic [3:0] GRID_MAX = 4'hF;
    localparam logic [7:0] DEST_LOC = 8'hFF;

endpackage

// File: rtl/maze_step_calc.sv
// Combinational single move on the 16x16 grid; flags moves that would leave it.
// Location format is {row[7:4], col[3:0]}.
module maze_step_calc
    import maze_pkg::*;
(
    input  logic [7:0] pos,
    input  logic [1:0] dir,
    output logic [7:0] next_pos,
    output logic       off_grid
);

    logic [3:0] row;
    logic [3:0] col;

    assign row = pos[7:4];
    assign col = pos[3:0];

    always_comb begin
        next_pos = pos;
        off_grid = 1'b0;
        unique case (dir)
            DIR_RIGHT: begin
                if (col == GRID_MAX) off_grid = 1'b1;
                else next_pos = {row, col + 4'd1};
            end
            DIR_DOWN: begin
                if (row == GRID_MAX) off_grid = 1'b1;
                else next_pos = {row + 4'd1, col};
            end
            DIR_LEFT: begin
                if (col == 4'd0) off_grid = 1'b1;
                else next_pos = {row, col - 4'd1};
            end
            DIR_UP: begin
                if (row == 4'd0) off_grid = 1'b1;
                else next_pos = {row - 4'd1, col};
            end
            default: begin
                next_pos = pos;
                off_grid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/maze_path_player.sv
// Replays the solver's move stack as a stream of grid locations from 00 to FF.
// One location per four cycles at best: EMIT, FETCH, WAIT, STEP.
module maze_path_player
    import maze_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] stkCount,
    output logic [7:0] stkAddr,
    output logic       stkRd,
    input  logic [1:0] stkData,
    output logic [7:0] locOut,
    output logic       locValid,
    input  logic       locReady,
    output logic       busy,
    output logic       done,
    output logic       err
);

    logic [2:0] state;
    logic [7:0] idx;
    logic [7:0] cnt;
    logic [7:0] pos;
    logic [1:0] dir_reg;
    logic       err_q;
    logic [7:0] next_pos;
    logic       off_grid;

    maze_step_calc u_step (
        .pos      (pos),
        .dir      (dir_reg),
        .next_pos (next_pos),
        .off_grid (off_grid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            idx     <= 8'd0;
            cnt     <= 8'd0;
            pos     <= 8'd0;
            dir_reg <= 2'b00;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt   <= stkCount;
                        idx   <= 8'd0;
                        pos   <= 8'd0;
                        err_q <= 1'b0;
                        state <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (locReady) begin
                        if (idx < cnt) begin
                            state <= S_FETCH;
                        end else begin
                            // err must already be up in the cycle done pulses
                            if (pos != DEST_LOC) err_q <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end
                S_FETCH: state <= S_WAIT;
                S_WAIT: begin
                    dir_reg <= stkData;
                    state   <= S_STEP;
                end
                S_STEP: begin
                    if (off_grid) begin
                        err_q <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        pos   <= next_pos;
                        idx   <= idx + 8'd1;
                        state <= S_EMIT;
                    end
                end
                S_FIN: begin
                    if (pos != DEST_LOC) err_q <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign stkAddr  = idx;
    assign stkRd    = (state == S_FETCH);
    assign locOut   = pos;
    assign locValid = (state == S_EMIT);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_FIN);
    assign err      = err_q;

endmodule

// File: tb/tb_maze_path_player.sv
// Directed bench for maze_path_player with a one-cycle-latency stack model.
// Stall stability, path order, errors, reset and start-while-busy are checked.
module tb_maze_path_player;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] stkCount;
    logic [7:0] stkAddr;
    logic       stkRd;
    logic [1:0] stkData = 2'b00;
    logic [7:0] locOut;
    logic       locValid;
    logic       locReady;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int failures = 0;

    logic [1:0] stack [256];
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    logic [7:0] addrs [$];
    int         hs_cyc [$];
    logic       done_seen;
    logic       err_at_done;
    logic       timed_out;
    int         stall_err;

    maze_path_player dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stkCount (stkCount),
        .stkAddr  (stkAddr),
        .stkRd    (stkRd),
        .stkData  (stkData),
        .locOut   (locOut),
        .locValid (locValid),
        .locReady (locReady),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (stkRd) stkData <= stack[stkAddr];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic fill_alt();
        for (int i = 0; i < 256; i++) stack[i] = (i % 2 == 0) ? 2'b00 : 2'b01;
    endtask

    task automatic fill_edge();
        for (int i = 0; i < 256; i++) stack[i] = (i < 15) ? 2'b00 : 2'b01;
    endtask

    task automatic build_exp(input int n);
        logic [3:0] r;
        logic [3:0] c;
        r = 4'd0;
        c = 4'd0;
        exp_q.delete();
        exp_q.push_back(8'h00);
        for (int i = 0; i < n; i++) begin
            case (stack[i])
                2'b00: c = c + 4'd1;
                2'b01: r = r + 4'd1;
                2'b10: c = c - 4'd1;
                default: r = r - 4'd1;
            endcase
            exp_q.push_back({r, c});
        end
    endtask

    task automatic check_path(input string tag);
        check({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check(tag, got[i], exp_q[i]);
            else check(tag, 32'hDEAD, exp_q[i]);
        end
    endtask

    task automatic replay(input int n, input int rdy_pct, input int inject_at);
        logic       had_stall;
        logic [7:0] prev;
        logic       r;
        got.delete();
        addrs.delete();
        hs_cyc.delete();
        done_seen = 1'b0;
        err_at_done = 1'b0;
        timed_out = 1'b0;
        stall_err = 0;
        had_stall = 1'b0;
        prev = 8'h00;
        @(negedge clk);
        start = 1'b1;
        stkCount = n[7:0];
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (had_stall && !(locValid === 1'b1 && locOut === prev))
                stall_err++;
            if (stkRd) addrs.push_back(stkAddr);
            if (done) begin
                done_seen = 1'b1;
                err_at_done = err;
                break;
            end
            r = ($urandom_range(99) < rdy_pct);
            locReady = r;
            if (locValid && r) begin
                got.push_back(locOut);
                hs_cyc.push_back(c);
            end
            had_stall = locValid && !r;
            prev = locOut;
            start = (c == inject_at);
            stkCount = (c == inject_at) ? 8'd3 : n[7:0];
            @(negedge clk);
        end
        start = 1'b0;
        if (!done_seen) timed_out = 1'b1;
    endtask

    initial begin
        int guard;
        rst = 1'b0;
        start = 1'b0;
        stkCount = 8'd0;
        locReady = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", locValid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd", stkRd, 0);
        check("rst_addr", stkAddr, 0);
        check("rst_loc", locOut, 0);
        rst = 1'b1;

        // 30 alternating moves, consumer always ready
        fill_alt();
        build_exp(30);
        replay(30, 100, -1);
        check("alt_timeout", timed_out, 0);
        check("alt_done", done_seen, 1);
        check("alt_err", err_at_done, 0);
        check("alt_n", got.size(), 31);
        check("alt_l0", got[0], 8'h00);
        check("alt_l1", got[1], 8'h01);
        check("alt_l2", got[2], 8'h11);
        check("alt_l3", got[3], 8'h12);
        check("alt_last", got[30], 8'hFF);
        check("alt_span", hs_cyc[30] - hs_cyc[0], 120);
        check("alt_naddr", addrs.size(), 30);
        check_path("alt_path");

        // first move leaves the grid to the left
        stack[0] = 2'b10;
        replay(3, 100, -1);
        check("left_timeout", timed_out, 0);
        check("left_n", got.size(), 1);
        check("left_l0", got[0], 8'h00);
        check("left_done", done_seen, 1);
        check("left_err", err_at_done, 1);
        @(negedge clk);
        check("left_idle", busy, 0);
        check("left_err_held", err, 1);
        check("left_novalid", locValid, 0);

        // empty stack
        replay(0, 100, -1);
        check("zero_timeout", timed_out, 0);
        check("zero_n", got.size(), 1);
        check("zero_l0", got[0], 8'h00);
        check("zero_done", done_seen, 1);
        check("zero_err", err_at_done, 1);

        // along the top edge then down the right edge, random backpressure
        fill_edge();
        build_exp(30);
        replay(30, 40, -1);
        check("edge_timeout", timed_out, 0);
        check("edge_stall", stall_err, 0);
        check("edge_done", done_seen, 1);
        check("edge_err", err_at_done, 0);
        check("edge_l15", got[15], 8'h0F);
        check("edge_l16", got[16], 8'h1F);
        check("edge_last", got[30], 8'hFF);
        check_path("edge_path");

        // start pulse mid-replay must be ignored
        fill_alt();
        build_exp(30);
        replay(30, 100, 10);
        check("busy_timeout", timed_out, 0);
        check("busy_naddr", addrs.size(), 30);
        for (int i = 0; i < 30; i++) check("busy_addr", addrs[i], i);
        check("busy_err", err_at_done, 0);
        check_path("busy_path");

        // reset while in WAIT at idx 5
        @(negedge clk);
        locReady = 1'b1;
        start = 1'b1;
        stkCount = 8'd30;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!(stkRd && stkAddr == 8'd5) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("rstw_reach", guard < 200, 1);
        @(negedge clk);
        check("rstw_inwait", {busy, stkRd, locValid}, 3'b100);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rstw_busy", busy, 0);
        check("rstw_valid", locValid, 0);
        check("rstw_rd", stkRd, 0);
        check("rstw_addr", stkAddr, 0);
        check("rstw_loc", locOut, 0);
        check("rstw_done", done, 0);
        check("rstw_err", err, 0);
        fill_edge();
        build_exp(30);
        replay(30, 70, -1);
        check("rstw_timeout", timed_out, 0);
        check("rstw_fin_err", err_at_done, 0);
        check_path("rstw_path");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maze_path_player.md
MAZE_PATH_PLAYER -- requirements
Module: maze_path_player

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-low.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous active-low reset; sampled on clk rising edge.
REQ-004 start  input  1  one-cycle pulse; begins replay of the solved path; ignored unless in IDLE.
REQ-005 stkCount  input  8  number of direction entries on the solver's move stack, sampled on start.
REQ-006 stkAddr  output  8  stack read address, 0 = oldest (first) move.
REQ-007 stkRd  output  1  stack read strobe; stkData is valid exactly one cycle after stkRd=1.
REQ-008 stkData  input  2  direction code: 00 = col+1, 01 = row+1, 10 = col-1, 11 = row-1.
REQ-009 locOut  output  8  replayed location {row[7:4], col[3:0]}.
REQ-010 locValid  output  1  locOut holds a valid location.
REQ-011 locReady  input  1  consumer accepts locOut when locValid=1 and locReady=1 in the same cycle.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at the end of a replay.
REQ-014 err  output  1  held high with done, and until the next start, when the replay failed.

Function
REQ-015 FSM states SHALL be IDLE, EMIT, FETCH, WAIT, STEP and FIN.
REQ-016 IDLE -> EMIT on start: latch stkCount into cnt, set idx=0, pos=8'h00, clear err.
REQ-017 EMIT: drive locOut=pos and locValid=1, holding both stable until handshake; on handshake go to FETCH if idx<cnt, else FIN.
REQ-018 FETCH: stkRd=1, stkAddr=idx for exactly one cycle -> WAIT.
REQ-019 WAIT: capture stkData into dirReg -> STEP.
REQ-020 STEP: compute the next position from pos and dirReg, increment idx, then go to EMIT.
REQ-021 STEP: if the move would leave the 16x16 grid (col 15 +right, col 0 -left, row 15 +down, row 0 -up), it SHALL set err=1, leave pos unchanged, and go to FIN without emitting.
REQ-022 Row and column arithmetic SHALL be 4-bit and checked, never wrapping.
REQ-023 FIN: done=1 for one cycle -> IDLE.
REQ-024 In FIN, err SHALL also be set if the final pos != 8'hFF (path did not reach the destination).
REQ-025 stkCount=0 SHALL emit 8'h00 once, then end with done=1 and err=1.
REQ-026 Emitted locations SHALL be exactly cnt+1 on success, in path order, starting with 8'h00 and ending with 8'hFF.
REQ-027 The throughput bound SHALL be 4 cycles per location when locReady is held high.
REQ-028 locValid SHALL never drop before its handshake; locReady=1 with locValid=0 SHALL have no effect.
REQ-029 start while busy SHALL be ignored.

Reset
REQ-030 rst=0 at a clk edge SHALL force IDLE from any state, including mid-replay; the replay is abandoned and not resumed.
REQ-031 Reset values SHALL be: stkAddr=0, stkRd=0, locOut=0, locValid=0, busy=0, done=0, err=0, idx=0, cnt=0, pos=0.

Structure
REQ-032 The direction codes, the state encoding, and the constants GRID_MAX=4'hF and DEST_LOC=8'hFF SHALL live in a shared maze package used by the solver controller and this block.
REQ-033 One sub-module, maze_step_calc, SHALL be used: a combinational pos+dir -> next pos with an offGrid flag.

Verification
REQ-034 The bench SHALL cover a 30-entry stack alternating 00/01 with locReady=1 -> 31 locations 00,01,11,12,...,FF; done=1, err=0.
REQ-035 The bench SHALL cover first entry 10 (left from 00) -> emits 00 only; done=1, err=1; no second locValid.
REQ-036 The bench SHALL cover stkCount=0 -> emits 00; done=1, err=1.
REQ-037 The bench SHALL cover the path 15x00 then 15x01 with locReady toggling randomly -> locOut stable while stalled; final FF; err=0.
REQ-038 The bench SHALL cover rst=0 during WAIT at idx=5 -> next cycle IDLE with all outputs 0; a new start replays from 00.
REQ-039 The bench SHALL cover a start pulse while busy -> no restart; idx sequence on stkAddr unchanged.
